// File: rtl/serial_addsub.sv
// serial_addsub: bit/chunk-serial adder/subtractor.
//
// An operation is requested with start while idle. The operands are latched and the result is
// produced one CHUNK-bit slice per clock, LSB slice first, with the carry rippled between
// slices in a register. After N = WIDTH/CHUNK slices the block returns to idle and pulses
// done for one cycle; sum, c_out and ovf are valid in that cycle and hold afterwards.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 2)
//   CHUNK  bits processed per clock; must divide WIDTH exactly
//
// Ports:
//   clk    clock, all state updates on the rising edge
//   rst    synchronous active-high reset
//   start  begin an operation (ignored while busy)
//   a, b   operands, sampled with start
//   c_in   carry in for add, sampled with start (ignored for subtract)
//   sub    0: a + b + c_in, 1: a - b; sampled with start
//   sum    registered result (partial bits may change while busy)
//   c_out  registered carry out of the MSB (subtract: 1 = no borrow)
//   ovf    registered two's-complement overflow
//   busy   operation in progress
//   done   one-cycle pulse, result valid

module serial_addsub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e state_q, state_d;

  // Latched operands stay constant for the whole operation; slices are picked by the counter.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;
  logic             ovf_q;
  logic             done_q;

  logic [IdxW-1:0]  slice_lsb;
  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_cmsb;
  logic             last_slice;

  assign slice_lsb  = IdxW'(cnt_q * CHUNK);
  assign a_slice    = a_q[slice_lsb +: CHUNK];
  assign b_slice    = b_q[slice_lsb +: CHUNK];
  assign last_slice = (cnt_q == LastCnt);

  // Ripple-carry add of one slice. slice_cmsb is the carry into the slice's top bit, which on
  // the last slice is the carry into bit WIDTH-1 needed for the overflow flag.
  always_comb begin
    logic ripple;
    ripple     = carry_q;
    slice_cmsb = carry_q;
    slice_sum  = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) begin
        slice_cmsb = ripple;
      end
      slice_sum[i] = a_slice[i] ^ b_slice[i] ^ ripple;
      ripple       = (a_slice[i] & b_slice[i]) | (ripple & (a_slice[i] ^ b_slice[i]));
    end
    slice_cout = ripple;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_slice) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            // Subtract as a + ~b + 1.
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            carry_q <= sub ? 1'b1 : c_in;
            cnt_q   <= '0;
          end
        end
        StRun: begin
          sum_q[slice_lsb +: CHUNK] <= slice_sum;
          carry_q                   <= slice_cout;
          cnt_q                     <= cnt_q + 1'b1;
          if (last_slice) begin
            c_out_q <= slice_cout;
            ovf_q   <= slice_cmsb ^ slice_cout;
            done_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    busy  = (state_q == StRun);
    done  = done_q;
    sum   = sum_q;
    c_out = c_out_q;
    ovf   = ovf_q;
  end

endmodule
